// File: rtl/lif_param_serializer.sv
// Serializes one LIF parameter set (wa, wb, leak, thr_min, thr_max) into the
// loader's framed bit stream: START cycle, 40 data bits MSB-first, then a guard gap.
module lif_param_serializer #(
   parameter int GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       start,
   input  logic [2:0] wa,
   input  logic [2:0] wb,
   input  logic [1:0] leak,
   input  logic [7:0] thr_min,
   input  logic [7:0] thr_max,
   output logic       serial_data_out,
   output logic       load_enable_out,
   output logic       busy,
   output logic       done,
   output logic       abort,
   output logic       sat_flag
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [5:0] BIT_LAST = 6'd39;

   typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

   state_t        state_reg, state_next;
   logic [5:0]    bit_count_reg, bit_count_next;
   logic [GW-1:0] gap_count_reg, gap_count_next;
   logic          aborted_reg, aborted_next;
   logic          sat_reg, sat_next;
   logic [2:0]    wa_reg, wa_next;
   logic [2:0]    wb_reg, wb_next;
   logic [1:0]    leak_reg, leak_next;
   logic [6:0]    thr_min_reg, thr_min_next;
   logic [6:0]    thr_max_reg, thr_max_next;
   logic          serial_next, load_next, busy_next, done_next, abort_next;
   logic [39:0]   frame;

   // Each field is its 7-bit value followed by a pad bit the loader never captures.
   assign frame = {4'b0, wa_reg, 1'b0, 4'b0, wb_reg, 1'b0, 5'b0, leak_reg, 1'b0,
                   thr_min_reg, 1'b0, thr_max_reg, 1'b0};

   always_comb begin
      state_next     = state_reg;
      bit_count_next = bit_count_reg;
      gap_count_next = gap_count_reg;
      aborted_next   = aborted_reg;
      sat_next       = sat_reg;
      wa_next        = wa_reg;
      wb_next        = wb_reg;
      leak_next      = leak_reg;
      thr_min_next   = thr_min_reg;
      thr_max_next   = thr_max_reg;

      case (state_reg)
         IDLE: begin
            if (enable && start) begin
               state_next     = START;
               bit_count_next = 6'd0;
               gap_count_next = '0;
               aborted_next   = 1'b0;
               wa_next        = wa;
               wb_next        = wb;
               leak_next      = leak;
               thr_min_next   = thr_min[7] ? 7'h7F : thr_min[6:0];
               thr_max_next   = thr_max[7] ? 7'h7F : thr_max[6:0];
               sat_next       = thr_min[7] | thr_max[7];
            end
         end
         START: begin
            if (!enable) begin
               state_next     = GAP;
               aborted_next   = 1'b1;
               gap_count_next = '0;
            end else begin
               state_next     = DATA;
               bit_count_next = 6'd0;
            end
         end
         DATA: begin
            if (!enable) begin
               state_next     = GAP;
               aborted_next   = 1'b1;
               gap_count_next = '0;
            end else if (bit_count_reg == BIT_LAST) begin
               state_next     = GAP;
               gap_count_next = '0;
            end else begin
               bit_count_next = bit_count_reg + 6'd1;
            end
         end
         GAP: begin
            if (gap_count_reg == GAP_LAST) begin
               state_next     = IDLE;
               bit_count_next = 6'd0;
               gap_count_next = '0;
            end else begin
               gap_count_next = gap_count_reg + GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      load_next   = (state_next == START) || (state_next == DATA);
      serial_next = (state_next == DATA) && frame[BIT_LAST - bit_count_next];
      busy_next   = (state_next != IDLE);
      done_next   = (state_next == GAP) && (gap_count_next == GAP_LAST) && !aborted_next;
      abort_next  = (state_next == GAP) && (gap_count_next == GAP_LAST) && aborted_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         bit_count_reg   <= 6'd0;
         gap_count_reg   <= '0;
         aborted_reg     <= 1'b0;
         sat_reg         <= 1'b0;
         wa_reg          <= 3'd0;
         wb_reg          <= 3'd0;
         leak_reg        <= 2'd0;
         thr_min_reg     <= 7'd0;
         thr_max_reg     <= 7'd0;
         serial_data_out <= 1'b0;
         load_enable_out <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         abort           <= 1'b0;
      end else begin
         state_reg       <= state_next;
         bit_count_reg   <= bit_count_next;
         gap_count_reg   <= gap_count_next;
         aborted_reg     <= aborted_next;
         sat_reg         <= sat_next;
         wa_reg          <= wa_next;
         wb_reg          <= wb_next;
         leak_reg        <= leak_next;
         thr_min_reg     <= thr_min_next;
         thr_max_reg     <= thr_max_next;
         serial_data_out <= serial_next;
         load_enable_out <= load_next;
         busy            <= busy_next;
         done            <= done_next;
         abort           <= abort_next;
      end
   end

   assign sat_flag = sat_reg;

endmodule

// File: tb/tb_lif_param_serializer.sv
// Bench for lif_param_serializer: a per-frame expected-waveform queue model
// checked every cycle, plus literal checks on captured frames and burst timing.
module tb_lif_param_serializer;
   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       start = 1'b0;
   logic [2:0] wa = 3'd0;
   logic [2:0] wb = 3'd0;
   logic [1:0] leak = 2'd0;
   logic [7:0] thr_min = 8'd0;
   logic [7:0] thr_max = 8'd0;
   logic       serial_data_out, load_enable_out, busy, done, abort, sat_flag;

   lif_param_serializer #(.GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .start(start),
      .wa(wa), .wb(wb), .leak(leak), .thr_min(thr_min), .thr_max(thr_max),
      .serial_data_out(serial_data_out), .load_enable_out(load_enable_out),
      .busy(busy), .done(done), .abort(abort), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic sd; logic le; logic busy; logic done; logic abort;} exp_t;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t q[$];
   exp_t cur = '0;
   logic exp_sat = 1'b0;
   logic model_live = 1'b0;

   // Monitor state
   logic [39:0] cap = '0;
   int cyc = 0, run = 0, last_run = 0, last_rise = -1, last_period = 0;
   int done_cnt = 0, abort_cnt = 0;
   logic prev_le = 1'b0;

   function automatic exp_t mk(logic sd, logic le, logic b, logic d, logic a);
      exp_t e;
      e.sd = sd; e.le = le; e.busy = b; e.done = d; e.abort = a;
      return e;
   endfunction

   // Each field byte is the (clamped) value shifted left by one.
   function automatic logic [39:0] frame_of(int a, int b, int l, int mn, int mx);
      int cmn, cmx;
      cmn = (mn > 127) ? 127 : mn;
      cmx = (mx > 127) ? 127 : mx;
      return {8'(a * 2), 8'(b * 2), 8'(l * 2), 8'(cmn * 2), 8'(cmx * 2)};
   endfunction

   // Reference model: on acceptance, queue the whole frame's expected outputs.
   initial begin
      logic [39:0] f;
      forever begin
         @(posedge clk);
         model_live = 1'b1;
         if (reset) begin
            q.delete();
            cur = '0;
            exp_sat = 1'b0;
         end else if (cur.busy) begin
            if (cur.le && !enable) begin
               q.delete();
               for (int i = 0; i < GAP; i++) q.push_back(mk(0, 0, 1, 0, i == GAP - 1));
            end
            cur = (q.size() > 0) ? q.pop_front() : exp_t'('0);
         end else if (enable && start) begin
            f = frame_of(int'(wa), int'(wb), int'(leak), int'(thr_min), int'(thr_max));
            exp_sat = (thr_min > 8'd127) || (thr_max > 8'd127);
            q.push_back(mk(0, 1, 1, 0, 0));
            for (int i = 0; i < 40; i++) q.push_back(mk(f[39 - i], 1, 1, 0, 0));
            for (int i = 0; i < GAP; i++) q.push_back(mk(0, 0, 1, i == GAP - 1, 0));
            cur = q.pop_front();
         end else begin
            cur = '0;
         end
      end
   end

   // Per-cycle compare plus monitor bookkeeping.
   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            n_cmp++;
            if ({serial_data_out, load_enable_out, busy, done, abort} !== cur ||
                sat_flag !== exp_sat) begin
               n_bad++;
               $display("FAIL cycle_model t=%0t got sd,le,busy,done,abort,sat=%b%b%b%b%b%b want %b%b%b%b%b%b",
                        $time, serial_data_out, load_enable_out, busy, done, abort, sat_flag,
                        cur.sd, cur.le, cur.busy, cur.done, cur.abort, exp_sat);
            end
         end
         cyc++;
         if (load_enable_out === 1'b1) begin
            cap = {cap[38:0], serial_data_out};
            if (!prev_le) begin
               if (last_rise >= 0) last_period = cyc - last_rise;
               last_rise = cyc;
            end
            run++;
         end else begin
            if (prev_le) last_run = run;
            run = 0;
         end
         prev_le = (load_enable_out === 1'b1);
         if (done === 1'b1) done_cnt++;
         if (abort === 1'b1) abort_cnt++;
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(string name, longint got, longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wait_end(int max);
      int k = 0;
      int bd = done_cnt;
      int ba = abort_cnt;
      while (done_cnt == bd && abort_cnt == ba && k < max) begin
         tick(1);
         k++;
      end
      if (k >= max) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_end timeout after %0d cycles want done/abort", k);
      end
   endtask

   task automatic launch(int a, int b, int l, int mn, int mx);
      wa = 3'(a); wb = 3'(b); leak = 2'(l); thr_min = 8'(mn); thr_max = 8'(mx);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      int d0, a0, k;
      tick(3);
      check("reset_outputs", {serial_data_out, load_enable_out, busy, done, abort, sat_flag}, 0);
      reset = 1'b0;
      enable = 1'b1;
      tick(2);

      // Nominal frame
      d0 = done_cnt;
      launch(5, 3, 2, 40, 100);
      wait_end(100);
      check("frame_a_bits", cap, 40'h0A060450C8);
      check("frame_a_le_run", last_run, 41);
      check("frame_a_done", done_cnt - d0, 1);
      check("frame_a_sat", sat_flag, 0);
      tick(2);

      // Saturating thresholds, then a frame that clears sat_flag
      launch(5, 3, 2, 200, 255);
      wait_end(100);
      check("sat_bits", cap, 40'h0A0604FEFE);
      check("sat_flag_set", sat_flag, 1);
      tick(2);
      launch(1, 7, 3, 30, 80);
      check("sat_flag_cleared", sat_flag, 0);
      wait_end(100);
      check("frame_c_bits", cap, 40'h020E063CA0);
      tick(2);

      // Abort: enable dropped during data bit 17 (cycle 19)
      d0 = done_cnt; a0 = abort_cnt;
      launch(2, 2, 1, 10, 20);
      tick(18);
      enable = 1'b0;
      wait_end(100);
      check("abort_pulse", abort_cnt - a0, 1);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_le_run", last_run, 19);
      tick(1);
      check("abort_busy_low", busy, 0);
      enable = 1'b1;
      tick(1);

      // Reset during data bit 25 (cycle 27), then a full frame
      launch(6, 1, 0, 127, 128);
      tick(26);
      reset = 1'b1;
      tick(1);
      check("midreset_outputs", {serial_data_out, load_enable_out, busy, done, abort, sat_flag}, 0);
      reset = 1'b0;
      tick(1);
      d0 = done_cnt;
      launch(3, 4, 1, 50, 60);
      wait_end(100);
      check("post_reset_le_run", last_run, 41);
      check("post_reset_done", done_cnt - d0, 1);
      tick(2);

      // Back-to-back frames with start held high
      d0 = done_cnt;
      wa = 3'd7; wb = 3'd0; leak = 2'd3; thr_min = 8'd1; thr_max = 8'd126;
      start = 1'b1;
      for (int i = 0; i < 3; i++) wait_end(100);
      start = 1'b0;
      check("b2b_done", done_cnt - d0, 3);
      check("b2b_period", last_period, 42 + GAP);
      check("b2b_le_run", last_run, 41);
      tick(2);

      // Start pulsed while busy is ignored
      d0 = done_cnt;
      launch(4, 5, 2, 99, 33);
      tick(19);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_end(100);
      tick(5);
      check("busy_start_done", done_cnt - d0, 1);
      check("busy_start_idle", busy, 0);

      // Randomized frames with occasional aborts and stray starts
      for (int n = 0; n < 30; n++) begin
         launch($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 255), $urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(1, 41);
            tick(k - 1);
            enable = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            tick($urandom_range(1, 40));
            start = 1'b1;
            tick(1);
            start = 1'b0;
         end
         wait_end(100);
         enable = 1'b1;
         tick($urandom_range(1, 4));
      end

      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
